// File: rtl/led_seq_pkg.sv
// Shared types and period table for the LED pattern sequencer.
// Imported by the tick divider and the sequencer top.
package led_seq_pkg;

    localparam int SPEED_N = 4;

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_SHIFT  = 2'd3
    } mode_e;

    // Cycles per pattern step: 1s, 0.5s, 0.25s, 0.1s
    function automatic int unsigned period_ticks(
        input int unsigned clkFreq,
        input int unsigned idx
    );
        int unsigned div;
        case (idx)
            0:       div = 1;
            1:       div = 2;
            2:       div = 4;
            default: div = 10;
        endcase
        return clkFreq / div;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_tick_divider.sv
// Free-running tick counter with clear, hold and terminal strobe.
// oTick is combinational; the caller registers it.
module tick_divider
    import led_seq_pkg::*;
#(
    parameter int CNT_W = 26
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             iEn,
    input  logic             iClr,
    input  logic [CNT_W-1:0] iTerm,
    output logic             oTick
);

    logic [CNT_W-1:0] rCnt;
    logic             atTerm;

    assign atTerm = (rCnt == iTerm);
    assign oTick  = iEn & ~iClr & atTerm;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rCnt <= '0;
        end else if (iClr) begin
            rCnt <= '0;
        end else if (iEn) begin
            rCnt <= atTerm ? '0 : rCnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: speed/mode selection, pattern stepping,
// active-low LED drive.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int CLK_FREQ = 27_000_000,
    parameter int LED_W    = 6,
    parameter int WRAP_VAL = 60,
    parameter int CNT_W    = 26
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             iSpeedBtn,
    input  logic             iModeBtn,
    input  logic             iPause,
    output logic [LED_W-1:0] oLED,
    output logic [1:0]       oSpeedIdx,
    output logic [1:0]       oMode,
    output logic             oTick
);

    localparam int IDX_W = $clog2(SPEED_N);

    localparam logic [CNT_W-1:0] TERM0 =
        CNT_W'(period_ticks(CLK_FREQ, 0) - 1);
    localparam logic [CNT_W-1:0] TERM1 =
        CNT_W'(period_ticks(CLK_FREQ, 1) - 1);
    localparam logic [CNT_W-1:0] TERM2 =
        CNT_W'(period_ticks(CLK_FREQ, 2) - 1);
    localparam logic [CNT_W-1:0] TERM3 =
        CNT_W'(period_ticks(CLK_FREQ, 3) - 1);

    localparam logic [LED_W-1:0] WRAP = LED_W'(WRAP_VAL);
    localparam logic [LED_W-1:0] ONE  = LED_W'(1);

    if (WRAP_VAL > (2 ** LED_W) - 1) begin : gBadWrap
        $error("WRAP_VAL does not fit in LED_W bits");
    end

    if (longint'(CLK_FREQ) - 1 >= (longint'(1) << CNT_W)) begin : gBadCnt
        $error("CNT_W too narrow for CLK_FREQ-1");
    end

    logic [IDX_W-1:0] rSpeedIdx;
    mode_e            rMode, nMode;
    logic             rDirUp, nDirUp, stepDirUp;
    logic [LED_W-1:0] rPattern, nPattern, stepPattern;
    logic             rTick, divTick, clr;
    logic [CNT_W-1:0] term;

    // Any press restarts the period and swallows a coincident tick
    assign clr = iSpeedBtn | iModeBtn;

    always_comb begin
        unique case (rSpeedIdx)
            2'd0: term = TERM0;
            2'd1: term = TERM1;
            2'd2: term = TERM2;
            2'd3: term = TERM3;
        endcase
    end

    tick_divider #(
        .CNT_W (CNT_W)
    ) uDiv (
        .CLK    (CLK),
        .RESETn (RESETn),
        .iEn    (~iPause),
        .iClr   (clr),
        .iTerm  (term),
        .oTick  (divTick)
    );

    always_comb begin
        stepPattern = rPattern;
        stepDirUp   = rDirUp;
        unique case (rMode)
            MODE_UP:
                stepPattern = (rPattern == WRAP) ? '0 : rPattern + ONE;
            MODE_DOWN:
                stepPattern = (rPattern == '0) ? WRAP : rPattern - ONE;
            MODE_BOUNCE: begin
                if (rDirUp) begin
                    if (rPattern == WRAP) begin
                        stepDirUp   = 1'b0;
                        stepPattern = WRAP - ONE;
                    end else begin
                        stepPattern = rPattern + ONE;
                    end
                end else begin
                    if (rPattern == '0) begin
                        stepDirUp   = 1'b1;
                        stepPattern = ONE;
                    end else begin
                        stepPattern = rPattern - ONE;
                    end
                end
            end
            MODE_SHIFT:
                stepPattern = {rPattern[LED_W-2:0], rPattern[LED_W-1]};
        endcase
    end

    always_comb begin
        nMode    = rMode;
        nDirUp   = rDirUp;
        nPattern = rPattern;
        if (iModeBtn) begin
            nMode    = mode_e'(rMode + 2'd1);
            nDirUp   = 1'b1;
            nPattern = (nMode == MODE_SHIFT) ? ONE : '0;
        end else if (divTick) begin
            nPattern = stepPattern;
            nDirUp   = stepDirUp;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rSpeedIdx <= '0;
            rMode     <= MODE_UP;
            rDirUp    <= 1'b1;
            rPattern  <= '0;
            rTick     <= 1'b0;
        end else begin
            if (iSpeedBtn) begin
                rSpeedIdx <= rSpeedIdx + IDX_W'(1);
            end
            rMode    <= nMode;
            rDirUp   <= nDirUp;
            rPattern <= nPattern;
            rTick    <= divTick;
        end
    end

    assign oLED      = ~rPattern;
    assign oSpeedIdx = rSpeedIdx;
    assign oMode     = rMode;
    assign oTick     = rTick;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer at CLK_FREQ=100.
// Expected ticks are queued with stimulus and popped on each oTick.
module tb_led_pattern_sequencer;

    localparam int CLK_FREQ = 100;
    localparam int LED_W    = 6;
    localparam int WRAP_VAL = 60;
    localparam int CNT_W    = 8;
    localparam int BUDGET   = 400;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    logic iSpeedBtn = 1'b0;
    logic iModeBtn = 1'b0;
    logic iPause = 1'b0;
    logic [LED_W-1:0] oLED;
    logic [1:0] oSpeedIdx;
    logic [1:0] oMode;
    logic oTick;

    always #5 CLK = ~CLK;

    led_pattern_sequencer #(
        .CLK_FREQ (CLK_FREQ),
        .LED_W    (LED_W),
        .WRAP_VAL (WRAP_VAL),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .iSpeedBtn (iSpeedBtn),
        .iModeBtn  (iModeBtn),
        .iPause    (iPause),
        .oLED      (oLED),
        .oSpeedIdx (oSpeedIdx),
        .oMode     (oMode),
        .oTick     (oTick)
    );

    typedef struct {
        int         gap;
        logic [5:0] pat;
        logic [1:0] idx;
        logic [1:0] mode;
    } exp_t;

    typedef struct {
        int   pre;
        bit   spd;
        bit   mod;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   nChk = 0;
    int   nFail = 0;
    bit   sawTick;

    task automatic check(string name, int act, int exp);
        nChk++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic expectTick(int gap, logic [5:0] pat,
                              logic [1:0] idx, logic [1:0] mode);
        exp_t e;
        e.gap  = gap;
        e.pat  = pat;
        e.idx  = idx;
        e.mode = mode;
        sb.push_back(e);
    endtask

    // Counts edges until oTick, then pops and compares one expectation
    task automatic waitTick(int already);
        exp_t e;
        int n;
        logic [5:0] led;
        e = sb.pop_front();
        n = already;
        forever begin
            @(posedge CLK);
            #1;
            n++;
            if (oTick || n >= BUDGET) break;
        end
        led = ~e.pat;
        check("tick_seen", int'(oTick), 1);
        check("tick_gap", n, e.gap);
        check("tick_led", int'(oLED), int'(led));
        check("tick_idx", int'(oSpeedIdx), int'(e.idx));
        check("tick_mode", int'(oMode), int'(e.mode));
    endtask

    task automatic press(bit s, bit m);
        iSpeedBtn = s;
        iModeBtn  = m;
        @(posedge CLK);
        #1;
        iSpeedBtn = 1'b0;
        iModeBtn  = 1'b0;
    endtask

    task automatic pausedCycles(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            if (oTick) sawTick = 1'b1;
        end
    endtask

    function automatic logic [5:0] tri_wave(int n);
        int m;
        m = n % 120;
        return (m <= 60) ? 6'(m) : 6'(120 - m);
    endfunction

    initial begin
        int shiftExp[6];
        shiftExp = '{2, 4, 8, 16, 32, 1};
        vecs = '{
            '{0,  1, 0, '{50,  6'd1,  2'd1, 2'd0}},
            '{13, 1, 0, '{25,  6'd2,  2'd2, 2'd0}},
            '{0,  1, 0, '{10,  6'd3,  2'd3, 2'd0}},
            '{0,  1, 0, '{100, 6'd4,  2'd0, 2'd0}},
            '{60, 1, 0, '{50,  6'd5,  2'd1, 2'd0}},
            '{0,  1, 0, '{25,  6'd6,  2'd2, 2'd0}},
            '{0,  1, 0, '{10,  6'd7,  2'd3, 2'd0}},
            '{0,  0, 1, '{10,  6'd60, 2'd3, 2'd1}},
            '{0,  0, 0, '{10,  6'd59, 2'd3, 2'd1}},
            '{0,  0, 0, '{10,  6'd58, 2'd3, 2'd1}}
        };

        repeat (3) @(posedge CLK);
        #1;
        check("rst_led", int'(oLED), 63);
        check("rst_idx", int'(oSpeedIdx), 0);
        check("rst_mode", int'(oMode), 0);
        check("rst_tick", int'(oTick), 0);
        RESETn = 1'b1;

        // UP from reset, including the 60 -> 0 wrap
        for (int n = 1; n <= 61; n++) begin
            expectTick(100, 6'(n % 61), 2'd0, 2'd0);
            waitTick(0);
        end

        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < vecs[i].pre; c++) begin
                @(posedge CLK);
                #1;
            end
            expectTick(vecs[i].e.gap, vecs[i].e.pat,
                       vecs[i].e.idx, vecs[i].e.mode);
            if (vecs[i].spd || vecs[i].mod)
                press(vecs[i].spd, vecs[i].mod);
            waitTick(0);
        end

        press(0, 1);
        check("bounce_mode", int'(oMode), 2);
        check("bounce_led0", int'(oLED), 63);
        for (int n = 1; n <= 122; n++) begin
            expectTick(10, tri_wave(n), 2'd3, 2'd2);
            waitTick(0);
        end

        press(0, 1);
        check("shift_mode", int'(oMode), 3);
        check("shift_led0", int'(oLED), 62);
        for (int i = 0; i < 6; i++) begin
            expectTick(10, 6'(shiftExp[i]), 2'd3, 2'd3);
            waitTick(0);
        end

        expectTick(100, 6'd1, 2'd0, 2'd0);
        press(1, 1);
        waitTick(0);

        // Pause 37 cycles mid-period
        repeat (40) @(posedge CLK);
        #1;
        iPause  = 1'b1;
        sawTick = 1'b0;
        pausedCycles(37);
        iPause = 1'b0;
        check("pause_notick", int'(sawTick), 0);
        expectTick(137, 6'd2, 2'd0, 2'd0);
        waitTick(77);

        // Mode press while paused
        repeat (20) @(posedge CLK);
        #1;
        iPause  = 1'b1;
        sawTick = 1'b0;
        pausedCycles(5);
        press(0, 1);
        check("pmode_mode", int'(oMode), 1);
        check("pmode_led", int'(oLED), 63);
        pausedCycles(30);
        iPause = 1'b0;
        check("pmode_notick", int'(sawTick), 0);
        expectTick(100, 6'd60, 2'd0, 2'd1);
        waitTick(0);

        // Speed+mode together on the terminal-count cycle
        repeat (99) @(posedge CLK);
        #1;
        expectTick(50, 6'd1, 2'd1, 2'd2);
        press(1, 1);
        check("both_notick", int'(oTick), 0);
        check("both_idx", int'(oSpeedIdx), 1);
        check("both_mode", int'(oMode), 2);
        check("both_led", int'(oLED), 63);
        waitTick(0);

        expectTick(25, 6'd2, 2'd2, 2'd2);
        press(1, 0);
        waitTick(0);
        expectTick(25, 6'd3, 2'd2, 2'd2);
        waitTick(0);

        // Asynchronous reset mid-period
        repeat (7) @(posedge CLK);
        #3;
        RESETn = 1'b0;
        #1;
        check("arst_led", int'(oLED), 63);
        check("arst_idx", int'(oSpeedIdx), 0);
        check("arst_mode", int'(oMode), 0);
        check("arst_tick", int'(oTick), 0);
        @(posedge CLK);
        #1;
        RESETn = 1'b1;
        expectTick(100, 6'd1, 2'd0, 2'd0);
        waitTick(0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChk, nFail);
        $finish;
    end

endmodule
